dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder end of the processor's data-memory load/store interface: accepts one word request at a time over a
//  valid/ready handshake, models a fixed access latency and returns read data or write completion.
//  Byte-addressed, little-endian store of 2^ADDR_BITS bytes; replaces the zero-latency data memory when the
//  pipeline gains a stall-capable memory stage.
// PARAMETERS
//  ADDR_BITS  10  byte-address bits implemented; array is 2^ADDR_BITS bytes
//  LATENCY    2   wait cycles between acceptance and access (0..15)
// PORTS
//  clk         in   1   clock; all state changes on posedge
//  reset       in   1   synchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept a request
//  req_write   in   1   1 = store, 0 = load
//  req_addr    in   32  byte address; must be word aligned
//  req_wdata   in   32  store data; bits [7:0] go to the lowest address
//  req_be      in   4   store byte enables; be[i] covers wdata[8i+7:8i]; ignored on loads
//  resp_valid  out  1   response present
//  resp_ready  in   1   initiator accepts response
//  resp_rdata  out  32  load data (0 on stores and on errors)
//  resp_err    out  1   request was misaligned or out of range
// BEHAVIOUR
//  - Reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0. Array contents are NOT
//    cleared. The array is named bytes [0:2^ADDR_BITS-1] so benches can preload it with $readmemh.
//  - FSM IDLE -> WAIT -> RESP -> IDLE. One outstanding request.
//  - IDLE: req_ready=1. On a posedge with req_valid=1: latch write/addr/wdata/be, load counter=LATENCY, go to WAIT.
//  - Request fields are sampled only at the acceptance edge; later changes are ignored.
//  - WAIT: req_ready=0. At each posedge: if counter!=0, decrement; else perform the access, go to RESP.
//  - Access edge:
//    - err = (addr[1:0]!=0) | (addr[31:ADDR_BITS]!=0).
//    - Load: rdata = {bytes[a+3], bytes[a+2], bytes[a+1], bytes[a]}.
//    - Store: write bytes[a+i] = wdata[8i+7:8i] for each i with be[i]=1; rdata=0.
//    - On err: no array change, rdata=0, resp_err=1.
//  - Latency: when acceptance is at edge N, resp_valid rises after edge N+1+LATENCY. Stores become visible to
//    later loads from that edge.
//  - RESP: resp_valid=1. resp_rdata and resp_err are held stable until the handshake. On a posedge with
//    resp_ready=1: resp_valid=0, resp_rdata=0, resp_err=0, go to IDLE.
//  - RESP, continued: req_ready=0, so a request offered during the handshake cycle is not taken. It is accepted
//    at the first edge in IDLE, so back-to-back throughput is LATENCY+3 cycles per request.
//  - resp_ready outside RESP is ignored. req_valid outside IDLE is ignored and not queued.
//  - Reset mid-operation: wins over everything. A pending store whose access edge has not occurred is dropped.
//    A completed store is retained. Any response is discarded.
//  - Address wrap: none. Any byte index >= 2^ADDR_BITS is an error, never aliased.
// TESTING
//  - Reset: hold reset 2 cycles -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
//  - Store then load, LATENCY=2:
//    - Store 0xDEADBEEF to 0x10 with be=4'hF, accepted at edge N -> resp_valid after edge N+3, rdata=0,
//      bytes[0x10]=0xEF, bytes[0x13]=0xDE.
//    - Load from 0x10 -> rdata=0xDEADBEEF, err=0.
//  - Partial store: be=4'b0010, wdata=0x0000AA00 to 0x10, then load 0x10 -> 0xDEADAAEF.
//  - Errors:
//    - Load 0x12 -> err=1, rdata=0.
//    - Store to 0x400 with ADDR_BITS=10 -> err=1, array unchanged.
//  - Backpressure: hold resp_ready=0 for 5 cycles with req_valid=1 -> resp_valid/rdata stable, no new
//    acceptance. Raise resp_ready -> next request accepted exactly 1 cycle after the handshake edge.
//  - Reset asserted in WAIT during a store to 0x20 (previously 0x11223344) -> IDLE next cycle, resp_valid never
//    rises, load 0x20 returns 0x11223344. Repeat with LATENCY=0: resp_valid after edge N+1.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the pipeline (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency, byte-addressed little-endian data memory answering one
// load/store at a time over valid/ready request and response channels.
module dmem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_r;
    logic                   write_r;
    logic [31:0]            addr_r;
    logic [31:0]            wdata_r;
    logic [3:0]             be_r;
    logic [3:0]             cnt_r;
    logic                   req_ready_r;
    logic                   resp_valid_r;
    logic [31:0]            resp_rdata_r;
    logic                   resp_err_r;

    logic [7:0]             bytes [0:DEPTH-1];

    logic [ADDR_BITS-3:0]   word_s;
    logic                   err_s;
    logic                   access_s;
    logic                   store_s;
    logic [31:0]            rdata_s;

    // Decode the latched request; out-of-range addresses are never aliased
    always_comb begin
        word_s   = addr_r[ADDR_BITS-1:2];
        err_s    = (addr_r[1:0] != 2'b00) || ((addr_r >> ADDR_BITS) != 32'd0);
        access_s = (state_r == WAIT) && (cnt_r == 4'd0);
        store_s  = access_s && write_r && !err_s && !reset;
        rdata_s  = 32'd0;
        for (int i = 0; i < 4; i++) begin
            rdata_s[8*i +: 8] = bytes[{word_s, 2'(i)}];
        end
    end

    // Byte-lane writes at the access edge; contents deliberately survive reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (store_s && be_r[i]) begin
                bytes[{word_s, 2'(i)}] <= wdata_r[8*i +: 8];
            end
        end
    end

    // Request/response sequencing with registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            write_r      <= 1'b0;
            addr_r       <= 32'd0;
            wdata_r      <= 32'd0;
            be_r         <= 4'd0;
            cnt_r        <= 4'd0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_r     <= bus.req_write;
                        addr_r      <= bus.req_addr;
                        wdata_r     <= bus.req_wdata;
                        be_r        <= bus.req_be;
                        cnt_r       <= 4'(LATENCY);
                        req_ready_r <= 1'b0;
                        state_r     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= err_s;
                        resp_rdata_r <= (err_s || write_r) ? 32'd0 : rdata_s;
                        state_r      <= RESP;
                    end
                end
                RESP: begin
                    // Ready rises only after the handshake, so no request is taken on that edge
                    if (bus.resp_ready) begin
                        resp_valid_r <= 1'b0;
                        resp_rdata_r <= 32'd0;
                        resp_err_r   <= 1'b0;
                        req_ready_r  <= 1'b1;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    cnt_r        <= 4'd0;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_rdata_r <= 32'd0;
                    resp_err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance at LATENCY=2, one at LATENCY=0,
// sharing clock/reset and a common stimulus path selected by sel.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        resp_ready = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mdl [0:1][0:1023];

    dmem_responder_if bus2();
    dmem_responder_if bus0();

    assign bus2.req_valid  = req_valid & ~sel;
    assign bus2.req_write  = req_write;
    assign bus2.req_addr   = req_addr;
    assign bus2.req_wdata  = req_wdata;
    assign bus2.req_be     = req_be;
    assign bus2.resp_ready = resp_ready & ~sel;
    assign bus0.req_valid  = req_valid & sel;
    assign bus0.req_write  = req_write;
    assign bus0.req_addr   = req_addr;
    assign bus0.req_wdata  = req_wdata;
    assign bus0.req_be     = req_be;
    assign bus0.resp_ready = resp_ready & sel;

    wire        o_req_ready  = sel ? bus0.req_ready  : bus2.req_ready;
    wire        o_resp_valid = sel ? bus0.resp_valid : bus2.resp_valid;
    wire [31:0] o_resp_rdata = sel ? bus0.resp_rdata : bus2.resp_rdata;
    wire        o_resp_err   = sel ? bus0.resp_err   : bus2.resp_err;

    dmem_responder #(.ADDR_BITS(10), .LATENCY(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
    dmem_responder #(.ADDR_BITS(10), .LATENCY(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, push its expected response, then collect and compare it.
    // hold>0 keeps resp_ready low that many cycles while offering a load of 0x20.
    task automatic do_req(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input int hold, output int waited);
        exp_t e;
        int   acc;
        int   lat;
        lat = s ? 0 : 2;
        sel = s;
        req_write = w; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
        waited = 0;
        while (!o_req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_val("req_ready_before_accept", 32'(o_req_ready), 32'd1);
        e.err = (a[1:0] != 2'b00) || (a >= 32'd1024);
        e.rdata = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (w && !e.err && be[i]) mdl[s][int'(a[9:0]) + i] = d[8*i +: 8];
        end
        for (int i = 0; i < 4; i++) begin
            if (!w && !e.err) e.rdata[8*i +: 8] = mdl[s][int'(a[9:0]) + i];
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid = 1'b0; req_write = ~w; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
        @(negedge clk);
        for (int k = 0; k < 40 && !o_resp_valid; k++) @(negedge clk);
        check_val("resp_latency", 32'(cyc - acc), 32'(lat + 1));
        if (sb.size() == 0) begin
            check_val("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
        end
        if (hold > 0) begin
            req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20; req_be = 4'h0;
            for (int k = 0; k < hold; k++) begin
                check_val("bp_resp_valid", 32'(o_resp_valid), 32'd1);
                check_val("bp_resp_rdata", o_resp_rdata, e.rdata);
                check_val("bp_req_ready", 32'(o_req_ready), 32'd0);
                @(negedge clk);
            end
        end
        check_val("resp_rdata", o_resp_rdata, e.rdata);
        check_val("resp_err", 32'(o_resp_err), 32'(e.err));
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check_val("post_hs_valid", 32'(o_resp_valid), 32'd0);
        check_val("post_hs_rdata", o_resp_rdata, 32'd0);
        check_val("post_hs_err", 32'(o_resp_err), 32'd0);
        check_val("post_hs_ready", 32'(o_req_ready), 32'd1);
    endtask

    // Accept a full-word store, then reset before (or exactly at) its access edge
    task automatic rst_mid(input logic s, input logic [31:0] a, input logic [31:0] d);
        sel = s;
        req_write = 1'b1; req_addr = a; req_wdata = d; req_be = 4'hF; req_valid = 1'b1;
        check_val("rst_mid_ready", 32'(o_req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("rst_mid_idle_ready", 32'(o_req_ready), 32'd1);
        for (int k = 0; k < 6; k++) begin
            check_val("rst_mid_no_resp", 32'(o_resp_valid), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_val("rst_req_ready", 32'(bus2.req_ready), 32'd1);
        check_val("rst_resp_valid", 32'(bus2.resp_valid), 32'd0);
        check_val("rst_resp_rdata", bus2.resp_rdata, 32'd0);
        check_val("rst_resp_err", 32'(bus2.resp_err), 32'd0);
        check_val("rst_req_ready_l0", 32'(bus0.req_ready), 32'd1);

        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, w);
        check_val("byte_0x10", 32'(dut2.bytes[16]), 32'hEF);
        check_val("byte_0x13", 32'(dut2.bytes[19]), 32'hDE);
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0, w);
        do_req(1'b0, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, 0, w);
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0, w);
        do_req(1'b0, 1'b0, 32'h12, 32'h0, 4'h0, 0, w);
        do_req(1'b0, 1'b1, 32'h0, 32'h01020304, 4'hF, 0, w);
        do_req(1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, w);
        do_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0, w);
        do_req(1'b0, 1'b1, 32'h3FC, 32'hA5A55A5A, 4'hF, 0, w);
        do_req(1'b0, 1'b0, 32'h3FC, 32'h0, 4'h0, 0, w);

        do_req(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 5, w);
        do_req(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 0, w);
        check_val("bp_accept_next_cycle", 32'(w), 32'd0);

        rst_mid(1'b0, 32'h20, 32'hCAFEF00D);
        do_req(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 0, w);

        do_req(1'b1, 1'b1, 32'h20, 32'h55667788, 4'hF, 0, w);
        do_req(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 0, w);
        rst_mid(1'b1, 32'h20, 32'h99AABBCC);
        do_req(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 0, w);
        do_req(1'b1, 1'b0, 32'h21, 32'h0, 4'h0, 0, w);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
